// File: rtl/sd_cmd_tx_pkg.sv
// ----------------------------------------------------------------------------
// sd_cmd_tx_pkg
// Shared definitions for the SD CMD-line transmitter: frame field widths,
// fixed framing bits, CRC7 polynomial, FSM state encoding and a helper that
// assembles the 40-bit header/argument portion of a command frame.
// ----------------------------------------------------------------------------
package sd_cmd_tx_pkg;

    localparam int IDX_W   = 6;
    localparam int ARG_W   = 32;
    localparam int CRC_W   = 7;
    localparam int FRAME_W = 48;
    localparam int HDR_W   = 2 + IDX_W + ARG_W;   // bits fed through the CRC

    localparam logic START_BIT = 1'b0;
    localparam logic TX_BIT    = 1'b1;   // host-to-card direction
    localparam logic END_BIT   = 1'b1;
    localparam logic IDLE_BIT  = 1'b1;   // CMD line rests high

    // x^7 + x^3 + 1, x^7 term implicit in the feedback
    localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_CRC  = 3'd2,
        ST_END  = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    function automatic logic [HDR_W-1:0] build_header(
        input logic [IDX_W-1:0] idx,
        input logic [ARG_W-1:0] arg
    );
        return {START_BIT, TX_BIT, idx, arg};
    endfunction

endpackage

// File: rtl/sd_cmd_tx_crc7.sv
// ----------------------------------------------------------------------------
// sd_cmd_tx_crc7
// Serial CRC7 (x^7+x^3+1) generator with an unload mode. While iunload=0 each
// clock absorbs idata; while iunload=1 the register shifts left, presenting
// the CRC MSB first on ocrc.
// Ports:
//   iclk     in   clock
//   iclr     in   synchronous clear (takes priority over everything)
//   idata    in   serial data bit to absorb (ignored in unload mode)
//   iunload  in   1 = shift CRC out, 0 = accumulate
//   ocrc     out  current CRC MSB (registered)
// ----------------------------------------------------------------------------
module sd_cmd_tx_crc7
    import sd_cmd_tx_pkg::*;
(
    input  logic iclk,
    input  logic iclr,
    input  logic idata,
    input  logic iunload,
    output logic ocrc
);

    logic [CRC_W-1:0] r_crc;
    logic             w_fb;

    assign w_fb = idata ^ r_crc[CRC_W-1];
    assign ocrc = r_crc[CRC_W-1];

    always_ff @(posedge iclk) begin
        if (iclr) begin
            r_crc <= '0;
        end else if (iunload) begin
            r_crc <= {r_crc[CRC_W-2:0], 1'b0};
        end else begin
            r_crc <= {r_crc[CRC_W-2:0], 1'b0} ^ ({CRC_W{w_fb}} & CRC7_POLY);
        end
    end

endmodule

// File: rtl/sd_cmd_tx.sv
// ----------------------------------------------------------------------------
// sd_cmd_tx
// Serialises one SD command frame onto the CMD line, one bit per iclk:
// start, transmission, index[5:0], arg[31:0], CRC7, end bit; followed by
// GAP_BITS idle-high cycles before the block reports not-busy.
// Parameters:
//   GAP_BITS  idle cycles after the end bit (0..63)
// Ports:
//   iclk     in   bit clock
//   irst     in   asynchronous active-high reset
//   istart   in   command request, accepted only while obusy=0
//   iindex   in   command index, sampled on accept
//   iarg     in   command argument, sampled on accept
//   obusy    out  high from accept until the gap completes
//   odone    out  one-cycle pulse during the end-bit cycle
//   ocmd     out  serial CMD data, 1 when not driving
//   ocmd_oe  out  pad output enable, high during the 48 frame bits
// All outputs are decoded from registers only (state, shift MSB, CRC MSB).
// ----------------------------------------------------------------------------
module sd_cmd_tx
    import sd_cmd_tx_pkg::*;
#(
    parameter int GAP_BITS = 1
)(
    input  logic        iclk,
    input  logic        irst,
    input  logic        istart,
    input  logic [5:0]  iindex,
    input  logic [31:0] iarg,
    output logic        obusy,
    output logic        odone,
    output logic        ocmd,
    output logic        ocmd_oe
);

    localparam logic [5:0] DATA_LAST = 6'(HDR_W - 1);
    localparam logic [5:0] CRC_LAST  = 6'(CRC_W - 1);
    localparam logic [5:0] GAP_LAST  = (GAP_BITS > 0) ? 6'(GAP_BITS - 1) : 6'd0;

    state_t             r_state, w_state_next;
    logic [HDR_W-1:0]   r_shift, w_shift_next;
    logic [5:0]         r_cnt,   w_cnt_next;

    logic w_accept;
    logic w_crc_clr;
    logic w_crc_data;
    logic w_crc_unload;
    logic w_crc_bit;

    assign w_accept  = (r_state == ST_IDLE) && istart;
    // Clearing on the accept edge means the first DATA bit meets a zero CRC.
    assign w_crc_clr = irst | w_accept;

    sd_cmd_tx_crc7 u_crc7 (
        .iclk    (iclk),
        .iclr    (w_crc_clr),
        .idata   (w_crc_data),
        .iunload (w_crc_unload),
        .ocrc    (w_crc_bit)
    );

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_cnt_next   = r_cnt;
        ocmd         = IDLE_BIT;
        ocmd_oe      = 1'b0;
        obusy        = 1'b1;
        odone        = 1'b0;
        // Outside DATA the CRC shifts zeros; harmless because accept clears it.
        w_crc_data   = 1'b0;
        w_crc_unload = 1'b1;

        case (r_state)
            ST_IDLE: begin
                obusy = 1'b0;
                if (istart) begin
                    w_state_next = ST_DATA;
                    w_shift_next = build_header(iindex, iarg);
                    w_cnt_next   = '0;
                end
            end

            ST_DATA: begin
                ocmd         = r_shift[HDR_W-1];
                ocmd_oe      = 1'b1;
                w_crc_data   = r_shift[HDR_W-1];
                w_crc_unload = 1'b0;
                w_shift_next = {r_shift[HDR_W-2:0], 1'b0};
                if (r_cnt == DATA_LAST) begin
                    w_state_next = ST_CRC;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + 6'd1;
                end
            end

            ST_CRC: begin
                ocmd    = w_crc_bit;
                ocmd_oe = 1'b1;
                if (r_cnt == CRC_LAST) begin
                    w_state_next = ST_END;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + 6'd1;
                end
            end

            ST_END: begin
                ocmd       = END_BIT;
                ocmd_oe    = 1'b1;
                odone      = 1'b1;
                w_cnt_next = '0;
                if (GAP_BITS == 0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_GAP;
                end
            end

            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + 6'd1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// ----------------------------------------------------------------------------
// tb_sd_cmd_tx
// Directed bench for sd_cmd_tx. Two instances share clock and reset: dut has
// GAP_BITS=1, dut0 has GAP_BITS=0. Expected frames are hand-computed SD
// command frames (CMD0 -> 40_00000000_95, CMD17 -> 51_00000000_55,
// CMD8 0x1AA -> 48_000001AA_87).
// ----------------------------------------------------------------------------
module tb_sd_cmd_tx;

    logic        iclk;
    logic        irst;
    logic        istart,  istart0;
    logic [5:0]  iindex,  iindex0;
    logic [31:0] iarg,    iarg0;
    logic        obusy,   obusy0;
    logic        odone,   odone0;
    logic        ocmd,    ocmd0;
    logic        ocmd_oe, ocmd_oe0;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [47:0] F_CMD0  = 48'h40_00000000_95;
    localparam logic [47:0] F_CMD17 = 48'h51_00000000_55;
    localparam logic [47:0] F_CMD8  = 48'h48_000001AA_87;

    sd_cmd_tx #(.GAP_BITS(1)) dut (
        .iclk    (iclk),
        .irst    (irst),
        .istart  (istart),
        .iindex  (iindex),
        .iarg    (iarg),
        .obusy   (obusy),
        .odone   (odone),
        .ocmd    (ocmd),
        .ocmd_oe (ocmd_oe)
    );

    sd_cmd_tx #(.GAP_BITS(0)) dut0 (
        .iclk    (iclk),
        .irst    (irst),
        .istart  (istart0),
        .iindex  (iindex0),
        .iarg    (iarg0),
        .obusy   (obusy0),
        .odone   (odone0),
        .ocmd    (ocmd0),
        .ocmd_oe (ocmd_oe0)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic got, input logic exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    // Called in cycle 0 with istart already high; returns in cycle 48.
    task automatic run_frame(input string tag, input logic sel, input logic [47:0] frame,
                             input logic hold, input logic perturb);
        logic c, oe, dn, bz;
        for (int k = 1; k <= 48; k++) begin
            tick();
            if (k == 1 && !hold) begin
                if (sel) istart0 = 1'b0;
                else     istart  = 1'b0;
            end
            if (perturb && k >= 2 && k <= 30) begin
                istart = k[0];
                iarg   = $urandom;
                iindex = 6'(k);
            end
            if (perturb && k == 31) istart = 1'b0;
            c  = sel ? ocmd0    : ocmd;
            oe = sel ? ocmd_oe0 : ocmd_oe;
            dn = sel ? odone0   : odone;
            bz = sel ? obusy0   : obusy;
            chk({tag, " ocmd"},  k, c,  frame[48-k]);
            chk({tag, " oe"},    k, oe, 1'b1);
            chk({tag, " odone"}, k, dn, (k == 48));
            chk({tag, " obusy"}, k, bz, 1'b1);
        end
    endtask

    initial begin
        irst = 1'b0; istart = 1'b0; iindex = '0; iarg = '0;
        istart0 = 1'b0; iindex0 = '0; iarg0 = '0;
        #1 irst = 1'b1;
        #1;
        chk("rst ocmd",   0, ocmd,     1'b1);
        chk("rst oe",     0, ocmd_oe,  1'b0);
        chk("rst obusy",  0, obusy,    1'b0);
        chk("rst odone",  0, odone,    1'b0);
        chk("rst0 ocmd",  0, ocmd0,    1'b1);
        chk("rst0 oe",    0, ocmd_oe0, 1'b0);
        chk("rst0 obusy", 0, obusy0,   1'b0);
        tick(); tick();
        irst = 1'b0;
        tick();

        // CMD0, arg 0
        iindex = 6'd0; iarg = 32'h0; istart = 1'b1;
        run_frame("cmd0", 1'b0, F_CMD0, 1'b0, 1'b0);
        tick();
        chk("cmd0 gap ocmd",  49, ocmd,    1'b1);
        chk("cmd0 gap oe",    49, ocmd_oe, 1'b0);
        chk("cmd0 gap obusy", 49, obusy,   1'b1);
        chk("cmd0 gap odone", 49, odone,   1'b0);
        tick();
        chk("cmd0 idle obusy", 50, obusy,  1'b0);
        chk("cmd0 idle ocmd",  50, ocmd,   1'b1);

        // CMD17 with istart pulses and input changes during the frame
        iindex = 6'd17; iarg = 32'h0; istart = 1'b1;
        run_frame("cmd17", 1'b0, F_CMD17, 1'b0, 1'b1);
        for (int j = 49; j <= 56; j++) begin
            tick();
            chk("cmd17 noextra oe",   j, ocmd_oe, 1'b0);
            chk("cmd17 noextra ocmd", j, ocmd,    1'b1);
        end

        // Back-to-back CMD8 then CMD0 with istart held high
        iindex = 6'd8; iarg = 32'h0000_01AA; istart = 1'b1;
        run_frame("cmd8", 1'b0, F_CMD8, 1'b1, 1'b0);
        tick();
        chk("b2b gap ocmd",  49, ocmd,    1'b1);
        chk("b2b gap oe",    49, ocmd_oe, 1'b0);
        chk("b2b gap obusy", 49, obusy,   1'b1);
        iindex = 6'd0; iarg = 32'h0;
        tick();
        chk("b2b idle ocmd",  50, ocmd,    1'b1);
        chk("b2b idle oe",    50, ocmd_oe, 1'b0);
        chk("b2b idle obusy", 50, obusy,   1'b0);
        run_frame("b2b cmd0", 1'b0, F_CMD0, 1'b0, 1'b0);
        tick(); tick();

        // Reset in cycle 20 of a CMD17 frame
        iindex = 6'd17; iarg = 32'h0; istart = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) istart = 1'b0;
        end
        chk("pre-rst ocmd", 20, ocmd,    F_CMD17[28]);
        chk("pre-rst oe",   20, ocmd_oe, 1'b1);
        irst = 1'b1;
        #1;
        chk("midrst ocmd",  20, ocmd,    1'b1);
        chk("midrst oe",    20, ocmd_oe, 1'b0);
        chk("midrst obusy", 20, obusy,   1'b0);
        chk("midrst odone", 20, odone,   1'b0);
        tick(); tick();
        irst = 1'b0;
        tick();
        iindex = 6'd0; iarg = 32'h0; istart = 1'b1;
        run_frame("post-rst cmd0", 1'b0, F_CMD0, 1'b0, 1'b0);
        tick(); tick();

        // GAP_BITS=0 instance: CMD0 then CMD17 with istart held
        iindex0 = 6'd0; iarg0 = 32'h0; istart0 = 1'b1;
        run_frame("gap0 cmd0", 1'b1, F_CMD0, 1'b1, 1'b0);
        tick();
        chk("gap0 c49 obusy", 49, obusy0,   1'b0);
        chk("gap0 c49 ocmd",  49, ocmd0,    1'b1);
        chk("gap0 c49 oe",    49, ocmd_oe0, 1'b0);
        iindex0 = 6'd17;
        run_frame("gap0 cmd17", 1'b1, F_CMD17, 1'b0, 1'b0);
        tick();
        chk("gap0 end obusy", 49, obusy0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sd_cmd_tx.md
# sd_cmd_tx

Serialises one SD-bus command frame (start bit, transmission bit, 6-bit index, 32-bit argument, CRC7, end bit) onto the CMD line, one bit per iclk. It sits between the command controller, which supplies index/argument with a start pulse, and the CMD pad driver. Internally it feeds the 40 header/argument bits into the team's crc7 generator and then shifts the CRC out through it.

## Interface
- GAP_BITS, 1, idle-high CMD cycles inserted after the end bit before the block reports not-busy (0..63)
- iclk  in  1  bit clock; one CMD bit per rising edge
- irst  in  1  asynchronous, active-high reset
- istart  in  1  command request; accepted only on a cycle with obusy=0
- iindex  in  6  command index, sampled on accept
- iarg  in  32  command argument, sampled on accept
- obusy  out  1  high from the accept edge until the gap completes
- odone  out  1  one-cycle pulse during the end-bit cycle
- ocmd  out  1  serial CMD data; 1 whenever not driving
- ocmd_oe  out  1  pad output enable; high only during the 48 frame bits

## Operation
- States: IDLE, DATA (40 cycles), CRC (7 cycles), END (1 cycle), GAP (GAP_BITS cycles; skipped if 0).
- IDLE: ocmd=1, ocmd_oe=0, obusy=0. On istart=1, load 40-bit shift register {1'b0, 1'b1, iindex, iarg}, clear bit counter, go DATA, obusy<=1.
- DATA: ocmd=shift MSB; crc7 idata=shift MSB, iunload=0; shift left each cycle; after 40th bit go CRC.
- CRC: ocmd=crc7 ocrc (CRC MSB first), iunload=1, idata=0; after 7 cycles go END.
- END: ocmd=1, ocmd_oe=1, odone=1; then GAP (or IDLE if GAP_BITS=0).
- GAP: ocmd=1, ocmd_oe=0, obusy=1; after GAP_BITS cycles go IDLE.
- crc7 sync clear driven by (irst | accept); the accept edge clears it, so the first DATA bit enters a zero register.
- istart while obusy=1 is ignored; no queuing. iindex/iarg changes after accept have no effect.
- Reset: async; state->IDLE, ocmd=1, ocmd_oe=0, obusy=0, odone=0, shift register and counter 0. Reset mid-frame truncates the frame immediately; the line returns to idle-high with oe low.
- ocmd/ocmd_oe/odone/obusy derive only from registers (state, shift MSB, crc7 output); no combinational path from inputs.

## Timing
- istart high in cycle 0 (accepted at edge ending cycle 0) -> start bit on ocmd in cycle 1.
- Cycles 1-40: start, transmission, index[5:0], arg[31:0], MSB first; cycles 41-47: CRC[6:0]; cycle 48: end bit with odone=1.
- ocmd_oe high exactly cycles 1-48.
- obusy high cycles 1 through 48+GAP_BITS; next istart accepted in cycle 49+GAP_BITS, next start bit one cycle later.
- Counter: 6 bits, reused for DATA (0..39), CRC (0..6), GAP (0..GAP_BITS-1).

## Structure
- Shared package: frame field widths (index 6, arg 32, CRC 7, frame 48), state encoding, start/transmission/end bit constants.
- One sub-module: crc7 (x^7+x^3+1, serial in, unload mode), instantiated once.
- Everything else (FSM, counter, shift register, output mux) lives in sd_cmd_tx.

## Test plan
- CMD0, arg 0x00000000 -> ocmd cycles 1-48 = 0x40_00000000_95 MSB first, odone in cycle 48 only.
- CMD17, arg 0x00000000 -> frame 0x51_00000000_55; CMD8, arg 0x000001AA -> frame 0x48_000001AA_87.
- Back-to-back with GAP_BITS=1: istart held high -> second start bit exactly 2 cycles after first end bit; ocmd=1, oe=0 in between.
- istart pulses and iarg changes during frame -> ignored; frame unchanged, no extra frame.
- irst asserted in cycle 20 -> same-cycle ocmd=1, oe=0, obusy=0; next command after release produces correct CRC (CMD0 -> 0x95).
- GAP_BITS=0 -> obusy low in cycle 49, new accept there, start bit in cycle 50.
